// File: rtl/arch_reg_checker_if.sv
// ---------------------------------------------------------------------------
// arch_reg_checker_if : control, expected-table, register-read and status bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface arch_reg_checker_if #(
  parameter int XLEN        = 32,
  parameter int NREGS       = 32,
  parameter int CYCLE_LIMIT = 10000
);
  localparam int IW = $clog2(NREGS);
  localparam int CW = $clog2(CYCLE_LIMIT + 1);

  logic            start;
  logic            halt;
  logic            exp_we;
  logic [IW-1:0]   exp_idx;
  logic [XLEN-1:0] exp_data;
  logic            exp_chk;
  logic [IW-1:0]   rd_idx;
  logic [XLEN-1:0] rd_data;
  logic            busy;
  logic            done;
  logic            pass;
  logic            timeout;
  logic [IW:0]     err_count;
  logic [IW-1:0]   first_err_idx;
  logic [XLEN-1:0] first_err_got;
  logic [XLEN-1:0] first_err_exp;
  logic [CW-1:0]   cycle_count;

  modport master (
    output start, halt, exp_we, exp_idx, exp_data, exp_chk, rd_data,
    input  rd_idx, busy, done, pass, timeout, err_count,
           first_err_idx, first_err_got, first_err_exp, cycle_count
  );

  modport slave (
    input  start, halt, exp_we, exp_idx, exp_data, exp_chk, rd_data,
    output rd_idx, busy, done, pass, timeout, err_count,
           first_err_idx, first_err_got, first_err_exp, cycle_count
  );
endinterface

`default_nettype wire

// File: rtl/arch_reg_checker.sv
// ---------------------------------------------------------------------------
// arch_reg_checker : end-of-test architectural register scan and compare.
// Option macro ARCH_REG_CHECKER_TIMEOUT_FAIL_EN makes a timeout force fail.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arch_reg_checker #(
  parameter int XLEN        = 32,
  parameter int NREGS       = 32,
  parameter int CYCLE_LIMIT = 10000
) (
  input  logic              clk,
  input  logic              reset,
  arch_reg_checker_if.slave bus
);
  localparam int IW = $clog2(NREGS);
  localparam int CW = $clog2(CYCLE_LIMIT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [IW:0]   SCAN_LAST = (IW + 1)'(NREGS);
  localparam logic [CW-1:0] CYC_LIM   = CW'(CYCLE_LIMIT);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [IW:0]     scan_q, scan_d;
  logic [IW:0]     err_q, err_d;
  logic [IW-1:0]   fidx_q, fidx_d;
  logic [XLEN-1:0] fgot_q, fgot_d;
  logic [XLEN-1:0] fexp_q, fexp_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            tmo_q, tmo_d;
  logic [XLEN-1:0] val_q [NREGS];
  logic            chk_q [NREGS];

  logic            w_start_ok;
  logic            w_cmp_en;
  logic [IW-1:0]   w_cmp_idx;
  logic [XLEN-1:0] w_cmp_exp;
  logic            w_cmp_chk;
  logic            w_mis;

  assign w_start_ok = bus.start && (state_q == S_IDLE || state_q == S_DONE);

  // rd_data returns one cycle after rd_idx, so the compare trails the issue index by one
  assign w_cmp_en  = (state_q == S_SCAN) && (scan_q != '0);
  assign w_cmp_idx = scan_q[IW-1:0] - 1'b1;
  assign w_cmp_exp = (w_cmp_idx == '0) ? '0 : val_q[w_cmp_idx];
  assign w_cmp_chk = (w_cmp_idx == '0) || chk_q[w_cmp_idx];
  assign w_mis     = w_cmp_en && w_cmp_chk && (bus.rd_data != w_cmp_exp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      scan_q  <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fgot_q  <= '0;
      fexp_q  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        val_q[i] <= '0;
        chk_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      scan_q  <= scan_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fgot_q  <= fgot_d;
      fexp_q  <= fexp_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      if (bus.exp_we && state_q != S_SCAN && 32'(bus.exp_idx) < NREGS) begin
        val_q[bus.exp_idx] <= bus.exp_data;
        chk_q[bus.exp_idx] <= bus.exp_chk;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (bus.halt || cyc_q == CYC_LIM) state_d = S_SCAN;
      S_SCAN:  if (scan_q == SCAN_LAST) state_d = S_DONE;
      S_DONE:  if (bus.start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cyc_d  = cyc_q;
    scan_d = scan_q;
    err_d  = err_q;
    fidx_d = fidx_q;
    fgot_d = fgot_q;
    fexp_d = fexp_q;
    done_d = done_q;
    pass_d = pass_q;
    tmo_d  = tmo_q;
    if (w_start_ok) begin
      cyc_d  = '0;
      err_d  = '0;
      fidx_d = '0;
      fgot_d = '0;
      fexp_d = '0;
      done_d = 1'b0;
      pass_d = 1'b0;
      tmo_d  = 1'b0;
    end
    if (state_q == S_RUN) begin
      scan_d = '0;
      if (cyc_q != CYC_LIM) cyc_d = cyc_q + 1'b1;
      if (!bus.halt && cyc_q == CYC_LIM) tmo_d = 1'b1;
    end
    if (state_q == S_SCAN) begin
      scan_d = scan_q + 1'b1;
      if (w_mis) begin
        err_d = err_q + 1'b1;
        if (err_q == '0) begin
          fidx_d = w_cmp_idx;
          fgot_d = bus.rd_data;
          fexp_d = w_cmp_exp;
        end
      end
      if (scan_q == SCAN_LAST) begin
        done_d = 1'b1;
`ifdef ARCH_REG_CHECKER_TIMEOUT_FAIL_EN
        pass_d = (err_d == '0) && !tmo_q;
`else
        pass_d = (err_d == '0);
`endif
      end
    end
  end

  always_comb begin
    bus.rd_idx = '0;
    if (state_q == S_SCAN && scan_q != SCAN_LAST) bus.rd_idx = scan_q[IW-1:0];
    bus.busy = (state_q == S_RUN) || (state_q == S_SCAN);
  end

  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.timeout       = tmo_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = fidx_q;
  assign bus.first_err_got = fgot_q;
  assign bus.first_err_exp = fexp_q;
  assign bus.cycle_count   = cyc_q;
endmodule

`default_nettype wire

// File: doc/arch_reg_checker.md
ARCH_REG_CHECKER -- requirements
Module: arch_reg_checker

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning architectural register width.
REQ-002 SHALL have parameter NREGS, default 32, meaning number of architectural registers checked.
REQ-003 SHALL have parameter CYCLE_LIMIT, default 10000, meaning run-cycle budget before a forced scan.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning reset; asynchronous and active-low.
REQ-006 SHALL have port start, input, 1, meaning begin the run phase (pulse).
REQ-007 SHALL have port halt, input, 1, meaning the core has retired its final instruction.
REQ-008 SHALL have ports exp_we/exp_idx/exp_data/exp_chk, inputs, 1/$clog2(NREGS)/XLEN/1, meaning write of expected value and check-enable for one register.
REQ-009 SHALL have port rd_idx, output, $clog2(NREGS), meaning register-file read address.
REQ-010 SHALL have port rd_data, input, XLEN, meaning register-file read data, valid one cycle after rd_idx.
REQ-011 SHALL have ports busy, done, pass, timeout, outputs, 1 each, meaning status.
REQ-012 SHALL have ports err_count ($clog2(NREGS)+1), first_err_idx ($clog2(NREGS)), first_err_got (XLEN), first_err_exp (XLEN), cycle_count ($clog2(CYCLE_LIMIT+1)), all outputs.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, SCAN, DONE.
REQ-014 SHALL move IDLE->RUN on start, clearing cycle_count, err_count, first_err_*, done, pass and timeout; start outside IDLE/DONE is ignored; start in DONE restarts the run.
REQ-015 SHALL increment cycle_count by 1 every RUN cycle, saturating at CYCLE_LIMIT.
REQ-016 SHALL move RUN->SCAN on halt, or when cycle_count equals CYCLE_LIMIT; halt wins when both occur in the same cycle, and timeout then stays 0.
REQ-017 SHALL set timeout=1 when RUN exits on the limit without halt.
REQ-018 SHALL store an expected table of NREGS entries (value plus check bit); exp_we writes are accepted in IDLE, RUN and DONE and ignored in SCAN.
REQ-019 SHALL reset every table entry's check bit to 0.
REQ-020 SHALL, in SCAN, issue rd_idx = 0..NREGS-1 on consecutive cycles and compare each rd_data one cycle later; the scan therefore lasts NREGS+1 cycles.
REQ-021 SHALL force register 0 to check against 0 regardless of table contents.
REQ-022 SHALL skip entries whose check bit is 0, with no count and no error.
REQ-023 SHALL increment err_count on each mismatch, and latch first_err_idx/got/exp only on the first mismatch of a run.
REQ-024 SHALL enter DONE after the last compare, asserting done=1 and pass = (err_count==0) and not timeout-fail (REQ-031).
REQ-025 SHALL hold busy=1 exactly in RUN and SCAN.
REQ-026 SHALL hold all outputs stable in DONE until the next start or reset.

Reset
REQ-027 SHALL, on reset low, immediately enter IDLE, including mid-RUN and mid-SCAN, and zero all outputs, counters and check bits.
REQ-028 SHALL drive rd_idx=0 while not in SCAN.
REQ-029 SHALL leave reset release synchronous to clk, with first state change no earlier than the first rising edge after release.

Configuration
REQ-030 SHALL use macro ARCH_REG_CHECKER_TIMEOUT_FAIL_EN.
REQ-031 SHALL, when ARCH_REG_CHECKER_TIMEOUT_FAIL_EN is defined, force pass=0 whenever timeout=1, even with zero mismatches.
REQ-032 SHALL, when ARCH_REG_CHECKER_TIMEOUT_FAIL_EN is undefined, make pass depend only on err_count while timeout is still reported.

Verification
REQ-033 SHALL cover this case: load x1=10, x7=13, x9=30 checked; start; halt at cycle 50; register file matches -> done after NREGS+1 scan cycles, pass=1, err_count=0, cycle_count=50.
REQ-034 SHALL cover this case: x24 expected 132, register file holds 128 -> err_count=1, first_err_idx=24, got=128, exp=132, pass=0.
REQ-035 SHALL cover this case: mismatches at x3 and x10 -> err_count=2, first_err_idx=3.
REQ-036 SHALL cover this case: no halt, CYCLE_LIMIT=100 -> scan begins after cycle 100, timeout=1; pass=0 with the macro defined, pass=1 without it (clean register file).
REQ-037 SHALL cover this case: halt in the same cycle as the limit -> timeout=0.
REQ-038 SHALL cover this case: reset low mid-SCAN -> IDLE immediately, busy=0, all outputs 0; a following start runs normally.
